// File: rtl/seq_multiplier_if.sv
// Handshake bundle for seq_multiplier: operand request channel and product response channel.
// The master drives operands and out_ready; the slave (the multiplier) returns the product.
interface seq_multiplier_if #(
   parameter int unsigned MCAND_WID  = 32,
   parameter int unsigned MPLIER_WID = 32
);
   logic                            in_valid;
   logic                            in_ready;
   logic [MCAND_WID-1:0]            multicand;
   logic [MPLIER_WID-1:0]           multiplier;
   logic                            is_signed;
   logic                            out_valid;
   logic                            out_ready;
   logic [MCAND_WID+MPLIER_WID-1:0] product;

   modport master (
      output in_valid, multicand, multiplier, is_signed, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, multicand, multiplier, is_signed, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle through a single MCAND_WID adder.
// Define MULT_SIGNED_EN to build two's-complement support (sign-magnitude around the core).
module seq_multiplier #(
   parameter int unsigned MCAND_WID  = 32,
   parameter int unsigned MPLIER_WID = 32
) (
   input logic             clk,
   input logic             rst,
   seq_multiplier_if.slave bus
);
   localparam int unsigned ProdWid = MCAND_WID + MPLIER_WID;
   localparam int unsigned CntWid  = (MPLIER_WID > 2) ? $clog2(MPLIER_WID) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e               state_q, state_d;
   logic [MCAND_WID-1:0]  mcand_q, mcand_d;
   logic [MCAND_WID-1:0]  acc_q, acc_d;
   logic [MPLIER_WID-1:0] mplier_q, mplier_d;
   logic [CntWid-1:0]     cnt_q, cnt_d;
   logic [ProdWid-1:0]    product_q, product_d;
   logic                  neg_q, neg_d, neg_in;

   logic [MCAND_WID-1:0]  mcand_in;
   logic [MPLIER_WID-1:0] mplier_in;
   logic [MCAND_WID:0]    sum;
   logic [ProdWid-1:0]    shifted;

`ifdef MULT_SIGNED_EN
   // Magnitude of the most-negative value wraps to 2^(W-1), which is correct as unsigned.
   always_comb begin
      mcand_in  = (bus.is_signed && bus.multicand[MCAND_WID-1]) ? -bus.multicand
                                                                 : bus.multicand;
      mplier_in = (bus.is_signed && bus.multiplier[MPLIER_WID-1]) ? -bus.multiplier
                                                                   : bus.multiplier;
      neg_in    = bus.is_signed & (bus.multicand[MCAND_WID-1] ^ bus.multiplier[MPLIER_WID-1]);
   end
`else
   logic unused_is_signed;
   assign unused_is_signed = bus.is_signed;
   assign mcand_in         = bus.multicand;
   assign mplier_in        = bus.multiplier;
   assign neg_in           = 1'b0;
`endif

   // Carry out of the add lands in the accumulator MSB after the right shift.
   assign sum     = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
   assign shifted = {sum, mplier_q[MPLIER_WID-1:1]};

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      product_d = product_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               mcand_d  = mcand_in;
               mplier_d = mplier_in;
               neg_d    = neg_in;
               acc_d    = '0;
               cnt_d    = CntWid'(MPLIER_WID - 1);
               state_d  = StBusy;
            end
         end
         StBusy: begin
            acc_d    = shifted[ProdWid-1:MPLIER_WID];
            mplier_d = shifted[MPLIER_WID-1:0];
            if (cnt_q == '0) begin
               product_d = neg_q ? -shifted : shifted;
               state_d   = StDone;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         acc_q     <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         product_q <= product_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.product   = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (32x32); expectations follow MULT_SIGNED_EN if defined.
module tb_seq_multiplier;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   seq_multiplier_if #(.MCAND_WID(32), .MPLIER_WID(32)) bus ();

   seq_multiplier #(.MCAND_WID(32), .MPLIER_WID(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Wait (bounded) for IDLE, issue one op, return product and latency counted from the
   // handshake cycle to the first cycle with out_valid high.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic hold_ready, output logic [63:0] p, output int lat);
      int guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready before accept", {63'd0, bus.in_ready}, 64'd1);
      bus.multicand  = a;
      bus.multiplier = b;
      bus.is_signed  = s;
      bus.in_valid   = 1'b1;
      bus.out_ready  = hold_ready;
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.multicand  = ~a;
      bus.multiplier = ~b;
      bus.is_signed  = ~s;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      p = bus.product;
   endtask

   logic [63:0] p;
   int          lat;

   initial begin
      vecs[0] = '{32'd3,          32'd5,          1'b0, 64'd15};
      vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
      vecs[2] = '{32'd0,          32'h1234_5678, 1'b0, 64'd0};
      vecs[3] = '{32'h8000_0000, 32'd2,          1'b0, 64'h1_0000_0000};
      vecs[4] = '{32'hFFFF_FFFF, 32'd2,          1'b0, 64'h1_FFFF_FFFE};
      vecs[5] = '{32'd7,          32'd6,          1'b1, 64'd42};
      vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
`ifdef MULT_SIGNED_EN
      vecs[7] = '{32'hFFFF_FFFF, 32'd7,          1'b1, 64'hFFFF_FFFF_FFFF_FFF9};
      vecs[8] = '{32'hFFFF_FFFF, 32'd2,          1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[9] = '{32'd3,          32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
`else
      vecs[7] = '{32'hFFFF_FFFF, 32'd7,          1'b1, 64'h6_FFFF_FFF9};
      vecs[8] = '{32'hFFFF_FFFF, 32'd2,          1'b1, 64'h1_FFFF_FFFE};
      vecs[9] = '{32'd3,          32'hFFFF_FFFB, 1'b1, 64'h2_FFFF_FFF1};
`endif

      bus.in_valid   = 1'b0;
      bus.multicand  = '0;
      bus.multiplier = '0;
      bus.is_signed  = 1'b0;
      bus.out_ready  = 1'b0;

      // Reset state
      @(negedge clk);
      check("reset in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("reset product", bus.product, 64'd0);
      rst = 1'b0;

      // Table: product, fixed latency, return to IDLE the next cycle
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, p, lat);
         check($sformatf("vec%0d product", i), p, vecs[i].exp);
         check($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
         @(negedge clk);
         check($sformatf("vec%0d idle out_valid", i), {63'd0, bus.out_valid}, 64'd0);
         check($sformatf("vec%0d idle in_ready", i), {63'd0, bus.in_ready}, 64'd1);
         check($sformatf("vec%0d product kept", i), bus.product, vecs[i].exp);
      end

      // Stall in DONE with in_valid toggling
      run_op(32'd9, 32'd9, 1'b0, 1'b0, p, lat);
      check("stall product", p, 64'd81);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid   = ~bus.in_valid;
         bus.multicand  = 32'(i + 100);
         bus.multiplier = 32'(i + 3);
         @(negedge clk);
         check("stall product stable", bus.product, 64'd81);
         check("stall in_ready", {63'd0, bus.in_ready}, 64'd0);
         check("stall out_valid", {63'd0, bus.out_valid}, 64'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("stall release out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("stall release in_ready", {63'd0, bus.in_ready}, 64'd1);
      run_op(32'd2, 32'd3, 1'b0, 1'b1, p, lat);
      check("after stall product", p, 64'd6);

      // Asynchronous reset mid-BUSY
      @(negedge clk);
      bus.multicand  = 32'd1000;
      bus.multiplier = 32'd1000;
      bus.in_valid   = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("busy in_ready", {63'd0, bus.in_ready}, 64'd0);
      #2 rst = 1'b1;
      #1;
      check("midreset in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("midreset out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("midreset product", bus.product, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(32'd3, 32'd5, 1'b0, 1'b1, p, lat);
      check("post-reset product", p, 64'd15);
      check("post-reset latency", 64'(lat), 64'd33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
